// File: rtl/flash_uart_tx.sv
// UART transmitter for flash read-back bytes: one shift frame plus a one-byte
// holding register, with an overflow pulse when a byte has to be dropped.
module flash_uart_tx #(
   parameter int CLK_FREQ   = 50_000_000,
   parameter int UART_BPS   = 9600,
   parameter bit PARITY_EN  = 1'b0,
   parameter bit PARITY_ODD = 1'b0
) (
   input  logic       sys_clk,
   input  logic       sys_rst,
   input  logic [7:0] pi_data,
   input  logic       pi_flag,
   output logic       tx,
   output logic       busy,
   output logic       hold_full,
   output logic       tx_done,
   output logic       overflow
);

   localparam int BAUD_CNT_MAX = CLK_FREQ / UART_BPS;
   localparam int CW = (BAUD_CNT_MAX > 1) ? $clog2(BAUD_CNT_MAX) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(BAUD_CNT_MAX - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

   state_t          state, state_n;
   logic [CW-1:0]   baud_cnt, cnt_n;
   logic [2:0]      bit_idx, idx_n;
   logic [7:0]      shift_q, shift_n;
   logic [7:0]      hold_q, hold_n;
   logic            hold_full_n;
   logic            tx_n, busy_n, done_n, ovf_n;
   logic            bit_end, stop_end;

   assign bit_end  = (state != IDLE) && (baud_cnt == CNT_LAST);
   assign stop_end = (state == STOP) && bit_end;

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state     <= IDLE;
         baud_cnt  <= '0;
         bit_idx   <= '0;
         shift_q   <= '0;
         hold_q    <= '0;
         hold_full <= 1'b0;
         tx        <= 1'b1;
         busy      <= 1'b0;
         tx_done   <= 1'b0;
         overflow  <= 1'b0;
      end else begin
         state     <= state_n;
         baud_cnt  <= cnt_n;
         bit_idx   <= idx_n;
         shift_q   <= shift_n;
         hold_q    <= hold_n;
         hold_full <= hold_full_n;
         tx        <= tx_n;
         busy      <= busy_n;
         tx_done   <= done_n;
         overflow  <= ovf_n;
      end
   end

   // Registered outputs are derived from the next state so they line up with it.
   always_comb begin
      state_n     = state;
      idx_n       = bit_idx;
      shift_n     = shift_q;
      hold_n      = hold_q;
      hold_full_n = hold_full;
      ovf_n       = 1'b0;

      case (state)
         IDLE: begin
            if (pi_flag) begin
               shift_n = pi_data;
               state_n = START;
            end
         end
         START: begin
            if (bit_end) begin
               state_n = DATA;
               idx_n   = '0;
            end
         end
         DATA: begin
            if (bit_end) begin
               if (bit_idx == 3'd7) state_n = PARITY_EN ? PARITY : STOP;
               else                 idx_n   = bit_idx + 3'd1;
            end
         end
         PARITY: begin
            if (bit_end) state_n = STOP;
         end
         STOP: begin
            if (bit_end) begin
               if (hold_full) begin
                  shift_n = hold_q;
                  state_n = START;
               end else if (pi_flag) begin
                  shift_n = pi_data;
                  state_n = START;
               end else begin
                  state_n = IDLE;
               end
            end
         end
         default: state_n = IDLE;
      endcase

      // At stop end the held byte moves out, so a same-cycle strobe is never dropped.
      if (pi_flag && (state != IDLE)) begin
         if (stop_end) begin
            if (hold_full) hold_n = pi_data;
         end else if (!hold_full) begin
            hold_n      = pi_data;
            hold_full_n = 1'b1;
         end else begin
            ovf_n = 1'b1;
         end
      end else if (stop_end && hold_full) begin
         hold_full_n = 1'b0;
      end

      if ((state == IDLE) || (state_n == IDLE) || bit_end) cnt_n = '0;
      else                                                  cnt_n = baud_cnt + 1'b1;

      case (state_n)
         IDLE:    tx_n = 1'b1;
         START:   tx_n = 1'b0;
         DATA:    tx_n = shift_n[idx_n];
         PARITY:  tx_n = (^shift_n) ^ PARITY_ODD;
         STOP:    tx_n = 1'b1;
         default: tx_n = 1'b1;
      endcase

      busy_n = (state_n != IDLE);
      done_n = (state_n == STOP) && (cnt_n == CNT_LAST);
   end

endmodule

// File: tb/tb_flash_uart_tx.sv
// Self-checking bench for flash_uart_tx: a line monitor decodes frames of the
// no-parity instance against a scoreboard; parity instances are checked bitwise.
module tb_flash_uart_tx;

   logic       sys_clk = 1'b0;
   logic       sys_rst = 1'b1;
   logic [7:0] pi_data;
   logic       pi_flag;

   logic tx0, busy0, hold0, done0, ovf0;
   logic txE, busyE, holdE, doneE, ovfE;
   logic txO, busyO, holdO, doneO, ovfO;

   int         checks = 0;
   int         errors = 0;
   int         cur = 0;
   int         ovf_seen = 0;
   logic [7:0] exp_q[$];

   always #5 sys_clk = ~sys_clk;

   flash_uart_tx #(.CLK_FREQ(1000), .UART_BPS(100), .PARITY_EN(1'b0), .PARITY_ODD(1'b0)) dut (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .pi_data(pi_data), .pi_flag(pi_flag),
      .tx(tx0), .busy(busy0), .hold_full(hold0), .tx_done(done0), .overflow(ovf0));

   flash_uart_tx #(.CLK_FREQ(1000), .UART_BPS(100), .PARITY_EN(1'b1), .PARITY_ODD(1'b0)) dut_even (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .pi_data(pi_data), .pi_flag(pi_flag),
      .tx(txE), .busy(busyE), .hold_full(holdE), .tx_done(doneE), .overflow(ovfE));

   flash_uart_tx #(.CLK_FREQ(1000), .UART_BPS(100), .PARITY_EN(1'b1), .PARITY_ODD(1'b1)) dut_odd (
      .sys_clk(sys_clk), .sys_rst(sys_rst), .pi_data(pi_data), .pi_flag(pi_flag),
      .tx(txO), .busy(busyO), .hold_full(holdO), .tx_done(doneO), .overflow(ovfO));

   // Line monitor: decodes each frame at mid-bit and pops the expected byte.
   initial begin
      bit         active;
      int         mcnt;
      logic [7:0] mbyte;
      logic [7:0] e;
      active = 1'b0;
      mcnt   = 0;
      mbyte  = '0;
      forever begin
         @(negedge sys_clk);
         if (ovf0 === 1'b1) ovf_seen++;
         if (sys_rst) begin
            active = 1'b0;
         end else if (!active) begin
            if (tx0 === 1'b0) begin
               active = 1'b1;
               mcnt   = 0;
            end
         end else begin
            mcnt++;
            if (mcnt == 5) begin
               checks++;
               if (tx0 !== 1'b0) begin
                  errors++;
                  $display("[TB] FAIL mon_start_bit got %b expected 0", tx0);
               end
            end else if (mcnt >= 15 && mcnt <= 85 && (mcnt % 10) == 5) begin
               mbyte[(mcnt - 15) / 10] = tx0;
            end else if (mcnt == 95) begin
               checks++;
               if (tx0 !== 1'b1) begin
                  errors++;
                  $display("[TB] FAIL mon_stop_bit got %b expected 1", tx0);
               end
               checks++;
               if (exp_q.size() == 0) begin
                  errors++;
                  $display("[TB] FAIL mon_unexpected_frame got %h expected none", mbyte);
               end else begin
                  e = exp_q.pop_front();
                  if (mbyte !== e) begin
                     errors++;
                     $display("[TB] FAIL mon_frame_byte got %h expected %h", mbyte, e);
                  end
               end
               active = 1'b0;
            end
         end
      end
   end

   initial begin
      #500000;
      $display("[TB] FAIL watchdog got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic goto(input int c);
      repeat (c - cur) @(negedge sys_clk);
      if (c > cur) cur = c;
   endtask

   task automatic strobe(input logic [7:0] d);
      pi_data = d;
      pi_flag = 1'b1;
      @(negedge sys_clk);
      pi_flag = 1'b0;
      cur++;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((busy0 || busyE || busyO || hold0 || holdE || holdO) && n < 500) begin
         @(negedge sys_clk);
         n++;
      end
      checks++;
      if (n >= 500) begin
         errors++;
         $display("[TB] FAIL idle_timeout got busy expected idle within 500 cycles");
      end
      repeat (3) @(negedge sys_clk);
   endtask

   task automatic test_reset();
      sys_rst = 1'b1;
      repeat (3) @(negedge sys_clk);
      sys_rst = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge sys_clk);
         checks++;
         if ({tx0, busy0, hold0, done0, ovf0, busyE, busyO} !== 7'b1000000) begin
            errors++;
            $display("[TB] FAIL reset_idle cycle %0d got %b expected 1000000", i,
                     {tx0, busy0, hold0, done0, ovf0, busyE, busyO});
         end
      end
   endtask

   task automatic test_single_byte();
      logic [9:0] pat;
      pat = 10'b1101001010;
      exp_q.push_back(8'hA5);
      cur = 0;
      strobe(8'hA5);
      checks++;
      if (tx0 !== 1'b0 || busy0 !== 1'b1) begin
         errors++;
         $display("[TB] FAIL single_latency got tx=%b busy=%b expected tx=0 busy=1", tx0, busy0);
      end
      for (int k = 0; k < 10; k++) begin
         goto(10 * k + 5);
         checks++;
         if (tx0 !== pat[k]) begin
            errors++;
            $display("[TB] FAIL single_bit%0d got %b expected %b", k, tx0, pat[k]);
         end
      end
      goto(99);
      checks++;
      if (done0 !== 1'b0) begin
         errors++;
         $display("[TB] FAIL single_done_early got %b expected 0", done0);
      end
      goto(100);
      checks++;
      if (done0 !== 1'b1 || busy0 !== 1'b1) begin
         errors++;
         $display("[TB] FAIL single_done got done=%b busy=%b expected done=1 busy=1", done0, busy0);
      end
      goto(101);
      checks++;
      if (done0 !== 1'b0 || busy0 !== 1'b0 || tx0 !== 1'b1) begin
         errors++;
         $display("[TB] FAIL single_end got done=%b busy=%b tx=%b expected 0 0 1", done0, busy0, tx0);
      end
      wait_idle();
   endtask

   task automatic test_back_to_back();
      exp_q.push_back(8'h3C);
      cur = 0;
      strobe(8'h3C);
      goto(25);
      checks++;
      if (hold0 !== 1'b0) begin
         errors++;
         $display("[TB] FAIL b2b_hold_before got %b expected 0", hold0);
      end
      exp_q.push_back(8'hC3);
      strobe(8'hC3);
      for (int c = 26; c <= 100; c++) begin
         goto(c);
         checks++;
         if (hold0 !== 1'b1) begin
            errors++;
            $display("[TB] FAIL b2b_hold cycle %0d got %b expected 1", c, hold0);
         end
      end
      checks++;
      if (tx0 !== 1'b1 || done0 !== 1'b1) begin
         errors++;
         $display("[TB] FAIL b2b_stop_end got tx=%b done=%b expected 1 1", tx0, done0);
      end
      goto(101);
      checks++;
      if (hold0 !== 1'b0 || tx0 !== 1'b0 || busy0 !== 1'b1) begin
         errors++;
         $display("[TB] FAIL b2b_no_gap got hold=%b tx=%b busy=%b expected 0 0 1", hold0, tx0, busy0);
      end
      wait_idle();
   endtask

   task automatic test_overflow();
      int base;
      base = ovf_seen;
      exp_q.push_back(8'h11);
      cur = 0;
      strobe(8'h11);
      goto(5);
      exp_q.push_back(8'h22);
      strobe(8'h22);
      for (int c = 6; c <= 15; c++) begin
         goto(c);
         checks++;
         if (ovf0 !== 1'b0) begin
            errors++;
            $display("[TB] FAIL ovf_early cycle %0d got %b expected 0", c, ovf0);
         end
      end
      strobe(8'h33);
      checks++;
      if (ovf0 !== 1'b1 || hold0 !== 1'b1) begin
         errors++;
         $display("[TB] FAIL ovf_pulse got ovf=%b hold=%b expected 1 1", ovf0, hold0);
      end
      goto(17);
      checks++;
      if (ovf0 !== 1'b0) begin
         errors++;
         $display("[TB] FAIL ovf_width got %b expected 0", ovf0);
      end
      wait_idle();
      checks++;
      if (ovf_seen - base != 1) begin
         errors++;
         $display("[TB] FAIL ovf_count got %0d expected 1", ovf_seen - base);
      end
   endtask

   task automatic test_parity();
      logic [10:0] pe;
      logic [10:0] po;
      pe = 11'b11000001110;
      po = 11'b10000001110;
      exp_q.push_back(8'h07);
      cur = 0;
      strobe(8'h07);
      for (int k = 0; k < 11; k++) begin
         goto(10 * k + 5);
         checks++;
         if (txE !== pe[k] || txO !== po[k]) begin
            errors++;
            $display("[TB] FAIL parity_bit%0d got even=%b odd=%b expected even=%b odd=%b",
                     k, txE, txO, pe[k], po[k]);
         end
      end
      goto(109);
      checks++;
      if (doneE !== 1'b0 || doneO !== 1'b0) begin
         errors++;
         $display("[TB] FAIL parity_done_early got %b%b expected 00", doneE, doneO);
      end
      goto(110);
      checks++;
      if (doneE !== 1'b1 || doneO !== 1'b1 || busyE !== 1'b1 || busyO !== 1'b1) begin
         errors++;
         $display("[TB] FAIL parity_done got done=%b%b busy=%b%b expected 11 11", doneE, doneO, busyE, busyO);
      end
      goto(111);
      checks++;
      if (busyE !== 1'b0 || busyO !== 1'b0) begin
         errors++;
         $display("[TB] FAIL parity_len got busy=%b%b expected 00", busyE, busyO);
      end
      wait_idle();
   endtask

   task automatic test_midframe_reset();
      cur = 0;
      strobe(8'h00);
      goto(45);
      checks++;
      if (tx0 !== 1'b0 || busy0 !== 1'b1) begin
         errors++;
         $display("[TB] FAIL mid_before got tx=%b busy=%b expected 0 1", tx0, busy0);
      end
      sys_rst = 1'b1;
      #1;
      checks++;
      if (tx0 !== 1'b1 || busy0 !== 1'b0 || txE !== 1'b1 || busyE !== 1'b0) begin
         errors++;
         $display("[TB] FAIL mid_async got tx=%b busy=%b expected 1 0", tx0, busy0);
      end
      repeat (2) @(negedge sys_clk);
      sys_rst = 1'b0;
      repeat (2) @(negedge sys_clk);
      exp_q.push_back(8'hFF);
      cur = 0;
      strobe(8'hFF);
      checks++;
      if (tx0 !== 1'b0 || busy0 !== 1'b1) begin
         errors++;
         $display("[TB] FAIL mid_restart got tx=%b busy=%b expected 0 1", tx0, busy0);
      end
      wait_idle();
   endtask

   initial begin
      pi_data = 8'h00;
      pi_flag = 1'b0;
      @(negedge sys_clk);
      test_reset();
      test_single_byte();
      test_back_to_back();
      test_overflow();
      test_parity();
      test_midframe_reset();
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("[TB] FAIL scoreboard_drain got %0d pending expected 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/flash_uart_tx.md
Name: flash_uart_tx

Overview:
- Serialises flash read-back bytes onto a UART line; directly downstream of the SPI flash read controller, consuming its pi_data/pi_flag byte strobe.
- One shift frame plus a one-byte holding register, so a byte strobed mid-frame is not lost.
- Upstream paces bytes at least one frame apart in normal operation; the holding register absorbs jitter.
- Loss is flagged on overflow.

Parameters:
- CLK_FREQ, 50_000_000, sys_clk frequency in Hz
- UART_BPS, 9600, baud rate; BAUD_CNT_MAX = CLK_FREQ/UART_BPS (integer division, truncated)
- PARITY_EN, 0, 1 inserts a parity bit after data bit 7
- PARITY_ODD, 0, 0 = even parity, 1 = odd parity; ignored when PARITY_EN = 0

Ports:
- sys_clk  input  1  system clock; one clock domain, all logic on rising edge
- sys_rst  input  1  asynchronous, active-high reset
- pi_data  input  8  byte to transmit; valid only when pi_flag = 1
- pi_flag  input  1  single-cycle byte strobe
- tx  output  1  UART serial line, idle high
- busy  output  1  high while a frame is being shifted (START through STOP)
- hold_full  output  1  holding register occupied
- tx_done  output  1  one-cycle pulse on the last cycle of each stop bit
- overflow  output  1  one-cycle pulse when an incoming byte is dropped

Behaviour:
- Reset (async, sys_rst = 1):
  - tx = 1, busy = 0, hold_full = 0, tx_done = 0, overflow = 0
  - State = IDLE; baud counter and bit index = 0; shift and hold registers = 0
  - Asserting reset mid-frame aborts the frame, and tx goes high immediately.
- Baud counter: counts 0..BAUD_CNT_MAX-1 only when state != IDLE. It wraps at BAUD_CNT_MAX-1 ("bit_end"), and each bit lasts exactly BAUD_CNT_MAX clocks. It is cleared on entering START.
- States: IDLE, START, DATA, PARITY, STOP.
  - IDLE: tx = 1. On pi_flag, latch pi_data into the shift register and go to START. tx drives 0 on the next clock edge (latency 1 cycle from the pi_flag sample).
  - START: tx = 0 for one bit. On bit_end go to DATA with bit index = 0.
  - DATA: tx = shift[bit index], LSB first. On bit_end, increment the index; when the index reaches 7 at bit_end, go to PARITY if PARITY_EN, else STOP.
  - PARITY: tx = XOR of the 8 data bits, XOR PARITY_ODD. On bit_end go to STOP.
  - STOP: tx = 1 for one bit. On bit_end, tx_done pulses, then:
    - if hold_full (or a pi_flag arrives in this same cycle), load that byte and go to START with no idle gap;
    - else go to IDLE.
- tx, busy and tx_done are registered outputs.
- Holding register:
  - pi_flag while busy and hold empty: store pi_data, and hold_full = 1 next cycle.
  - pi_flag while hold full and not at STOP bit_end: the new byte is dropped, the held byte is kept, and overflow pulses 1 cycle.
  - pi_flag at STOP bit_end with hold full: the held byte moves to the shifter, the new byte enters hold, hold_full stays 1, and there is no overflow.
  - pi_flag at STOP bit_end with hold empty: the new byte goes straight to the shifter, and hold_full stays 0.
- Frame length: 10 bits (11 with parity) × BAUD_CNT_MAX clocks.
- pi_flag held high for multiple cycles counts as one strobe per cycle; that is caller error, and the overflow rules apply.

Test Plan:
All scenarios use CLK_FREQ = 1000 and UART_BPS = 100, giving BAUD_CNT_MAX = 10.
- Reset idle: sys_rst pulsed, no strobes for 200 clocks -> tx = 1 and busy = 0 throughout; all pulses stay 0.
- Single byte: pi_flag with pi_data = 8'hA5 ->
  - tx falls 1 cycle later;
  - line sequence is 0,1,0,1,0,0,1,0,1,1, each bit 10 clocks;
  - tx_done pulses at clock 100 of the frame;
  - busy falls the next cycle.
- Back-to-back: 8'h3C, then 8'hC3 strobed 25 clocks later ->
  - hold_full = 1 from clock 26 until the first frame's STOP bit_end;
  - the second start bit begins the cycle after the first stop ends, with no idle gap;
  - both frames are correct.
- Overflow: bytes 8'h11, 8'h22 and 8'h33 strobed at clocks 0, 5 and 15 -> overflow pulses once, at the third strobe; frames 8'h11 then 8'h22 are sent; 8'h33 never appears.
- Parity: PARITY_EN = 1 with PARITY_ODD = 0, then with PARITY_ODD = 1, sending 8'h07 -> the parity bit is 1 (even) and 0 (odd) respectively; the frame is 110 clocks.
- Mid-frame reset: sys_rst asserted at clock 45 of a frame -> tx = 1 and busy = 0 asynchronously. After release, a new strobe of 8'hFF produces a clean frame.
